// File: rtl/qpsk_frame_sync.sv
// qpsk_frame_sync: frame synchroniser between the QPSK demodulator and the time display.
// Waits for the free-running 40-bit demodulator word to stay stable and checks the
// header and checksum of each stable word. A lock/loss state machine then publishes
// verified h/m/s time.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   para_in     - {header, h, m, s, checksum} from the demodulator
//   time_out    - last verified {h,m,s}, held between updates
//   time_vld    - one-cycle pulse when time_out is updated
//   locked      - high while the synchroniser is locked
//   frame_ok    - one-cycle pulse per good candidate frame
//   frame_err   - one-cycle pulse per bad candidate frame
//   err_cnt     - saturating count of bad candidate frames
module qpsk_frame_sync #(
  parameter logic [7:0]  HEADER     = 8'hcc,
  parameter logic [15:0] STABLE_CYC = 16'd5000,
  parameter logic [3:0]  LOCK_CNT   = 4'd3,
  parameter logic [3:0]  LOSS_CNT   = 4'd3,
  parameter logic [26:0] TIMEOUT    = 27'd99_999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [39:0] para_in,
  output logic [23:0] time_out,
  output logic        time_vld,
  output logic        locked,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [15:0] err_cnt
);

  localparam int unsigned WORD_W = 40;
  localparam int unsigned STAB_W = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned TMO_W  = 27;
  localparam int unsigned ERR_W  = 16;

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC - 16'd1);
  localparam logic [STAB_W-1:0] STAB_PRE = STAB_W'(STABLE_CYC - 16'd2);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   prev;
  logic [STAB_W-1:0]   stab_cnt;
  logic [CNT_W-1:0]    good_cnt, good_cnt_nxt;
  logic [CNT_W-1:0]    bad_cnt, bad_cnt_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_cnt_nxt;
  logic                cand_c;
  logic                good_c;
  logic [7:0]          sum_c;
  logic                frame_ok_nxt, frame_err_nxt, time_upd_nxt, locked_nxt;
  logic [ERR_W-1:0]    err_cnt_nxt;

  // Stability filter: count consecutive cycles the input matches its previous sample
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      stab_cnt <= '0;
    end else begin
      prev <= para_in;
      if (para_in != prev) begin
        stab_cnt <= '0;
      end else if (stab_cnt != STAB_MAX) begin
        stab_cnt <= stab_cnt + STAB_W'(1);
      end
    end
  end

  // Candidate fires only on the step into saturation, so a held word yields one candidate
  assign cand_c = (para_in == prev) && (stab_cnt == STAB_PRE);
  assign sum_c  = 8'(prev[31:24] + prev[23:16] + prev[15:8]);
  assign good_c = (prev[39:32] == HEADER) && (prev[7:0] == sum_c);

  // State and counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HUNT;
      good_cnt <= '0;
      bad_cnt  <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
      bad_cnt  <= bad_cnt_nxt;
      tmo_cnt  <= tmo_cnt_nxt;
    end
  end

  // Next-state and counter logic; a candidate takes priority over the timeout
  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    bad_cnt_nxt  = bad_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    case (state)
      HUNT: begin
        if (cand_c) begin
          if (good_c) begin
            good_cnt_nxt = CNT_W'(1);
            state_nxt    = (LOCK_CNT == 4'd1) ? LOCKED : CONFIRM;
          end else begin
            good_cnt_nxt = '0;
          end
        end
      end
      CONFIRM: begin
        if (cand_c) begin
          if (good_c) begin
            good_cnt_nxt = good_cnt + CNT_W'(1);
            if (good_cnt_nxt == LOCK_CNT) begin
              state_nxt = LOCKED;
            end
          end else begin
            good_cnt_nxt = '0;
            state_nxt    = HUNT;
          end
        end
      end
      LOCKED: begin
        if (cand_c) begin
          if (good_c) begin
            bad_cnt_nxt = '0;
            tmo_cnt_nxt = '0;
          end else begin
            bad_cnt_nxt = bad_cnt + CNT_W'(1);
            if (bad_cnt_nxt == LOSS_CNT) begin
              state_nxt = HUNT;
            end
          end
        end else if (tmo_cnt == TIMEOUT) begin
          state_nxt = HUNT;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
        end
        if (state_nxt != LOCKED) begin
          good_cnt_nxt = '0;
          bad_cnt_nxt  = '0;
          tmo_cnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt    = HUNT;
        good_cnt_nxt = '0;
        bad_cnt_nxt  = '0;
        tmo_cnt_nxt  = '0;
      end
    endcase
  end

  // Output decode: time is only published while locked or on the locking frame
  always_comb begin
    frame_ok_nxt  = cand_c && good_c;
    frame_err_nxt = cand_c && !good_c;
    locked_nxt    = (state_nxt == LOCKED);
    time_upd_nxt  = frame_ok_nxt && locked_nxt;
    err_cnt_nxt   = err_cnt;
    if (frame_err_nxt && (err_cnt != 16'hffff)) begin
      err_cnt_nxt = err_cnt + ERR_W'(1);
    end
  end

  // Output register
  always_ff @(posedge clk) begin
    if (rst) begin
      time_out  <= '0;
      time_vld  <= 1'b0;
      locked    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      time_vld  <= time_upd_nxt;
      locked    <= locked_nxt;
      frame_ok  <= frame_ok_nxt;
      frame_err <= frame_err_nxt;
      err_cnt   <= err_cnt_nxt;
      if (time_upd_nxt) begin
        time_out <= prev[31:8];
      end
    end
  end

endmodule

// File: tb/tb_qpsk_frame_sync.sv
// Testbench for qpsk_frame_sync: directed scenarios plus randomized frames, checked
// every cycle against a frame-level behavioural model.
module tb_qpsk_frame_sync;

  localparam int STAB = 4;
  localparam int LOCKN = 3;
  localparam int LOSSN = 2;
  localparam int TMO = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] para_in;
  logic [23:0] time_out;
  logic        time_vld;
  logic        locked;
  logic        frame_ok;
  logic        frame_err;
  logic [15:0] err_cnt;

  always #5 clk = ~clk;

  qpsk_frame_sync #(
    .HEADER     (8'hcc),
    .STABLE_CYC (16'd4),
    .LOCK_CNT   (4'd3),
    .LOSS_CNT   (4'd2),
    .TIMEOUT    (27'd200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .para_in   (para_in),
    .time_out  (time_out),
    .time_vld  (time_vld),
    .locked    (locked),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_cnt   (err_cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit started = 0;

  // Frame-level model state
  logic [39:0] hist[$];
  bit          m_locked;
  int          m_streak, m_bad, m_idle;
  logic [23:0] exp_time;
  logic        exp_vld, exp_ok, exp_err;
  logic [15:0] exp_errcnt;

  // Event records taken from the DUT for literal checks
  int ok_pulses = 0, err_pulses = 0, vld_pulses = 0;
  int lock_rise_cyc = -1, lock_fall_cyc = -1, last_vld_cyc = -1;
  logic locked_q = 1'b0;

  task automatic model_step();
    logic [39:0] w;
    logic [7:0]  h, m, s;
    int          n;
    bit          cand, good;
    if (rst) begin
      hist.delete();
      m_locked = 0; m_streak = 0; m_bad = 0; m_idle = 0;
      exp_time = '0; exp_vld = 0; exp_ok = 0; exp_err = 0; exp_errcnt = '0;
    end else begin
      w = para_in;
      hist.push_back(w);
      if (hist.size() > STAB + 1) void'(hist.pop_front());
      n = hist.size();
      // A candidate is the STAB-th consecutive sample of a word that was new at its start
      cand = 0;
      if (n >= STAB) begin
        cand = (hist[n-2] == w) && (hist[n-3] == w) && (hist[n-4] == w);
        if (n == STAB + 1 && hist[0] == w) cand = 0;
      end
      h = w[31:24]; m = w[23:16]; s = w[15:8];
      good = (w[39:32] == 8'hcc) && (int'(w[7:0]) == ((int'(h) + int'(m) + int'(s)) % 256));
      exp_ok = cand && good;
      exp_err = cand && !good;
      exp_vld = 0;
      if (exp_err && exp_errcnt != 16'hffff) exp_errcnt = exp_errcnt + 16'd1;
      if (!m_locked) begin
        if (cand) begin
          if (good) begin
            m_streak++;
            if (m_streak == LOCKN) begin
              m_locked = 1; m_streak = 0; m_bad = 0; m_idle = 0; exp_vld = 1;
            end
          end else begin
            m_streak = 0;
          end
        end
      end else if (cand) begin
        if (good) begin
          m_bad = 0; m_idle = 0; exp_vld = 1;
        end else begin
          m_bad++;
          if (m_bad == LOSSN) begin
            m_locked = 0; m_bad = 0; m_idle = 0;
          end
        end
      end else if (m_idle == TMO) begin
        m_locked = 0; m_idle = 0;
      end else begin
        m_idle++;
      end
      if (exp_vld) exp_time = w[31:8];
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    started = 1;
    model_step();
  end

  // Per-cycle compare against the model, plus event recording
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if ({time_out, time_vld, locked, frame_ok, frame_err, err_cnt} !==
          {exp_time, exp_vld, m_locked, exp_ok, exp_err, exp_errcnt}) begin
        failures++;
        $display("FAIL cycle_cmp cyc=%0d got tout=%h vld=%b lck=%b ok=%b err=%b ecnt=%0d exp tout=%h vld=%b lck=%b ok=%b err=%b ecnt=%0d",
                 cyc, time_out, time_vld, locked, frame_ok, frame_err, err_cnt,
                 exp_time, exp_vld, m_locked, exp_ok, exp_err, exp_errcnt);
      end
      if (frame_ok === 1'b1) ok_pulses++;
      if (frame_err === 1'b1) err_pulses++;
      if (time_vld === 1'b1) begin
        vld_pulses++;
        last_vld_cyc = cyc;
      end
      if (locked === 1'b1 && locked_q !== 1'b1) lock_rise_cyc = cyc;
      if (locked !== 1'b1 && locked_q === 1'b1) lock_fall_cyc = cyc;
      locked_q = locked;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic hold(input logic [39:0] w, input int n);
    para_in = w;
    repeat (n) @(negedge clk);
  endtask

  localparam logic [39:0] F1 = 40'hcc_01_02_03_06;
  localparam logic [39:0] F2 = 40'hcc_01_02_04_07;
  localparam logic [39:0] F3 = 40'hcc_01_02_05_08;
  localparam logic [39:0] GL = 40'hff_ff_ff_ff_ff;
  localparam logic [39:0] B1 = 40'hcc_01_02_06_00;
  localparam logic [39:0] B2 = 40'hcc_01_02_07_00;

  initial begin
    int t0, rise0;
    logic [39:0] w;
    logic [7:0]  h, m, s, hdr;
    int          k, len;

    // Reset
    rst = 1'b1;
    para_in = 40'hcc_12_34_56_9c;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outputs", {time_out, time_vld, locked, frame_ok, frame_err, err_cnt}, 64'd0);
    rst = 1'b0;

    // Lock acquisition
    hold(F1, 10);
    hold(F2, 10);
    t0 = cyc;
    hold(F3, 10);
    #2;
    chk("acq_ok_pulses", 64'(ok_pulses), 64'd3);
    chk("acq_vld_pulses", 64'(vld_pulses), 64'd1);
    chk("acq_lock_cycle", 64'(lock_rise_cyc), 64'(t0 + STAB));
    chk("acq_vld_with_lock", 64'(last_vld_cyc), 64'(t0 + STAB));
    chk("acq_time_out", 64'(time_out), 64'h010205);
    chk("acq_locked", 64'(locked), 64'd1);

    // Glitch while locked
    hold(GL, 2);
    hold(F3, 10);
    #2;
    chk("glitch_err_pulses", 64'(err_pulses), 64'd0);
    chk("glitch_err_cnt", 64'(err_cnt), 64'd0);
    chk("glitch_locked", 64'(locked), 64'd1);

    // Loss of lock on two bad frames
    hold(B1, 10);
    t0 = cyc;
    hold(B2, 10);
    #2;
    chk("loss_err_pulses", 64'(err_pulses), 64'd2);
    chk("loss_err_cnt", 64'(err_cnt), 64'd2);
    chk("loss_locked", 64'(locked), 64'd0);
    chk("loss_fall_cycle", 64'(lock_fall_cyc), 64'(t0 + STAB));
    chk("loss_time_out", 64'(time_out), 64'h010205);

    // Timeout with the final good word held
    hold(F1, 10);
    hold(F2, 10);
    t0 = cyc;
    hold(F3, 310);
    #2;
    rise0 = lock_rise_cyc;
    chk("tmo_lock_cycle", 64'(rise0), 64'(t0 + STAB));
    chk("tmo_fall_delay", 64'(lock_fall_cyc - rise0), 64'd201);
    chk("tmo_no_err", 64'(err_pulses), 64'd2);
    chk("tmo_locked", 64'(locked), 64'd0);

    // Reset mid-lock
    hold(F1, 10);
    hold(F2, 10);
    hold(F3, 10);
    #2;
    chk("pre_rst_locked", 64'(locked), 64'd1);
    chk("pre_rst_err_cnt", 64'(err_cnt), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_time_out", 64'(time_out), 64'd0);
    rst = 1'b0;
    hold(F1, 10);
    hold(F2, 10);
    #2;
    chk("relock_not_yet", 64'(locked), 64'd0);
    hold(F3, 10);
    #2;
    chk("relock_locked", 64'(locked), 64'd1);
    chk("relock_time_out", 64'(time_out), 64'h010205);

    // Randomized frames, glitches, long holds and occasional resets
    w = F3;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      k = $urandom_range(0, 9);
      h = 8'($urandom_range(0, 23));
      m = 8'($urandom_range(0, 59));
      s = 8'($urandom_range(0, 59));
      if (k < 5) begin
        w = {8'hcc, h, m, s, 8'(h + m + s)};
      end else if (k < 7) begin
        w = {8'hcc, h, m, s, 8'(h + m + s + 8'd1)};
      end else if (k < 8) begin
        hdr = 8'($urandom);
        if (hdr == 8'hcc) hdr = 8'h33;
        w = {hdr, h, m, s, 8'(h + m + s)};
      end
      if (w == 40'd0) w = 40'd1;
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 24) == 0) len = 230;
      hold(w, len);
    end
    #2;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qpsk_frame_sync.md
Name: qpsk_frame_sync

Overview:
- Sits directly downstream of the QPSK demodulator and upstream of the seven-segment time display.
- Watches the demodulator's free-running 40-bit parallel output and waits for it to stay stable.
- Validates each stable word against the frame header and checksum.
- Runs a lock/loss state machine and publishes verified h/m/s time with a valid strobe, a lock flag and error statistics.

Parameters:
- HEADER, 8'hcc, expected frame header byte.
- STABLE_CYC, 16'd5000, consecutive identical cycles before a word is treated as a candidate frame (min 2).
- LOCK_CNT, 4'd3, consecutive good frames required to enter LOCKED (min 1).
- LOSS_CNT, 4'd3, consecutive bad frames in LOCKED that force HUNT (min 1).
- TIMEOUT, 27'd99_999_999, cycles in LOCKED without a good frame before forcing HUNT.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- para_in  in  40  demodulated word: [39:32] header, [31:24] h, [23:16] m, [15:8] s, [7:0] checksum.
- time_out  out  24  verified {h,m,s}; held between updates.
- time_vld  out  1  one-cycle pulse when time_out is updated.
- locked  out  1  high while FSM is in LOCKED.
- frame_ok  out  1  one-cycle pulse per good candidate.
- frame_err  out  1  one-cycle pulse per bad candidate.
- err_cnt  out  16  saturating count of bad candidates since reset.

Behaviour:
- Reset values: time_out = 0, time_vld = 0, locked = 0, frame_ok = 0, frame_err = 0, err_cnt = 0, FSM = HUNT, all internal counters = 0, prev = 0.
- Stability filter:
  - prev <= para_in every cycle.
  - If para_in != prev, stab_cnt <= 0; otherwise stab_cnt increments, saturating at STABLE_CYC-1.
  - cand pulses for one cycle only on the cycle stab_cnt goes from STABLE_CYC-2 to STABLE_CYC-1.
  - A word that stays constant therefore yields exactly one candidate. A change shorter than STABLE_CYC yields none.
- Validity check: good = (para_in[39:32] == HEADER) and (para_in[7:0] == (h+m+s) mod 256, 8-bit wrap).
  - Evaluated on the word held in prev during the cand cycle.
- Result latency: frame_ok/frame_err, FSM transition, counter updates and time_out/time_vld all register one cycle after cand.
- err_cnt increments on frame_err and saturates at 16'hffff.
- HUNT:
  - Good candidate: good_cnt <= 1. If LOCK_CNT == 1, go to LOCKED; otherwise go to CONFIRM.
  - Bad candidate: stay in HUNT, good_cnt <= 0.
- CONFIRM:
  - Good candidate: good_cnt++. When good_cnt reaches LOCK_CNT, go to LOCKED.
  - Bad candidate: go to HUNT, good_cnt <= 0.
- LOCKED:
  - Good candidate: bad_cnt <= 0, tmo_cnt <= 0.
  - Bad candidate: bad_cnt++. When bad_cnt reaches LOSS_CNT, go to HUNT.
  - Otherwise tmo_cnt++ each cycle. When tmo_cnt == TIMEOUT, go to HUNT and clear tmo_cnt.
  - On leaving LOCKED: bad_cnt, good_cnt and tmo_cnt cleared.
- time_out/time_vld:
  - Updated with {h,m,s} of a good candidate only when the FSM is already LOCKED or is entering LOCKED on that candidate.
  - In HUNT/CONFIRM, time_out holds its last value and time_vld stays 0.
  - time_out is not cleared on loss of lock.
- locked is registered and equals (state == LOCKED). It rises in the same cycle as the time_vld of the locking frame.
- Simultaneous events: if a candidate evaluation and the timeout fall in the same cycle, the candidate wins. A good frame keeps lock; a bad frame counts toward LOSS_CNT and the timeout is ignored.
- rst asserted mid-operation returns everything to reset values on the next clock edge, regardless of FSM state or counter values.

Test Plan:
- Bench params: STABLE_CYC = 4, LOCK_CNT = 3, LOSS_CNT = 2, TIMEOUT = 200.
- Reset check: rst high for 3 cycles with para_in = 40'hcc_12_34_56_9c.
  - Response: all outputs 0 and locked = 0 throughout.
- Lock acquisition: three distinct good frames, each held 10 cycles, e.g. 40'hcc_01_02_03_06, 40'hcc_01_02_04_07, 40'hcc_01_02_05_08.
  - Response: frame_ok pulses ×3, and the third's result cycle comes 1 cycle after its cand.
  - Response: locked = 1, time_vld = 1 and time_out = 24'h010205 all appear in that same result cycle.
  - Response: no time_vld on the first two frames.
- Glitch rejection: while locked, insert 40'hff_ff_ff_ff_ff for 2 cycles between good frames.
  - Response: no frame_err, err_cnt unchanged, lock held.
- Loss: while locked, hold two different bad-checksum frames, e.g. 40'hcc_01_02_06_00 then 40'hcc_01_02_07_00, 10 cycles each.
  - Response: frame_err ×2, err_cnt += 2, locked falls 1 cycle after the second cand.
  - Response: time_out stays 24'h010205.
- Timeout: lock, then hold the final good word constant for 300 cycles.
  - Response: locked drops exactly 201 cycles after the lock-entry cycle, with no frame_err.
- Reset mid-lock: assert rst for 1 cycle while locked with err_cnt = 2.
  - Response: the next cycle shows locked = 0, err_cnt = 0, time_out = 0.
  - Response: relocking needs 3 new good frames.
